// File: rtl/alarm_ring_if.sv
// Alarm controller signal bundle: time/alarm digits and buttons in, buzzer/LED/state out.
// The master side is the time counter and button logic; the slave side is the controller.
interface alarm_ring_if;
    logic        tick_1hz;
    logic [15:0] time_digits;
    logic [7:0]  sec_digits;
    logic [15:0] alarm_digits;
    logic        alarm_armed;
    logic        adjusting;
    logic        stop_btn;
    logic        snooze_btn;
    logic        ringing;
    logic        alarm_led;
    logic        snoozing;
    logic [1:0]  state;

    // Inputs are level/pulse signals sampled every clk; there is no valid/ready
    // handshake. Buttons and tick are single-cycle pulses, the rest are levels.
    modport master (
        output tick_1hz, time_digits, sec_digits, alarm_digits,
        output alarm_armed, adjusting, stop_btn, snooze_btn,
        input  ringing, alarm_led, snoozing, state
    );

    modport slave (
        input  tick_1hz, time_digits, sec_digits, alarm_digits,
        input  alarm_armed, adjusting, stop_btn, snooze_btn,
        output ringing, alarm_led, snoozing, state
    );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/stop controller: triggers on the rising edge of an HH:MM:00 match,
// drives buzzer enable and a 0.5 Hz blinking LED, and counts snooze/timeout on 1 Hz ticks.
module alarm_ring_ctrl #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic        clk,
    input  logic        rst,
    alarm_ring_if.slave bus
);
    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int SC_W         = $clog2(SNOOZE_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RINGING = 2'b01,
        S_SNOOZE  = 2'b10
    } state_t;

    state_t          r_state;
    logic            r_match_d;
    logic [7:0]      r_ring_cnt;
    logic [SC_W-1:0] r_snooze_cnt;
    logic            r_led_phase;
    logic            r_ringing;
    logic            r_alarm_led;
    logic            r_snoozing;

    logic w_match;
    logic w_match_rise;

    assign w_match = bus.alarm_armed & ~bus.adjusting &
                     (bus.time_digits == bus.alarm_digits) &
                     (bus.sec_digits == 8'h00);
    // Edge detect keeps a stop during second 00 from re-triggering immediately.
    assign w_match_rise = w_match & ~r_match_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_match_d    <= 1'b0;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_led_phase  <= 1'b0;
            r_ringing    <= 1'b0;
            r_alarm_led  <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_match_d <= w_match;
            case (r_state)
                S_IDLE: begin
                    if (w_match_rise) begin
                        r_state     <= S_RINGING;
                        r_ring_cnt  <= '0;
                        r_led_phase <= 1'b1;
                        r_ringing   <= 1'b1;
                        r_alarm_led <= 1'b1;
                        r_snoozing  <= 1'b0;
                    end
                end
                S_RINGING: begin
                    if (!bus.alarm_armed || bus.stop_btn) begin
                        r_state     <= S_IDLE;
                        r_ringing   <= 1'b0;
                        r_alarm_led <= 1'b0;
                        r_snoozing  <= 1'b0;
                    end else if (bus.snooze_btn) begin
                        r_state      <= S_SNOOZE;
                        r_snooze_cnt <= SC_W'(SNOOZE_TICKS);
                        r_ringing    <= 1'b0;
                        r_alarm_led  <= 1'b0;
                        r_snoozing   <= 1'b1;
                    end else if (bus.tick_1hz) begin
                        if (r_ring_cnt == 8'(RING_TIMEOUT_S - 1)) begin
                            r_state     <= S_IDLE;
                            r_ringing   <= 1'b0;
                            r_alarm_led <= 1'b0;
                            r_snoozing  <= 1'b0;
                        end else begin
                            r_ring_cnt  <= r_ring_cnt + 8'd1;
                            r_led_phase <= ~r_led_phase;
                            r_alarm_led <= ~r_led_phase;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (!bus.alarm_armed || bus.stop_btn) begin
                        r_state     <= S_IDLE;
                        r_ringing   <= 1'b0;
                        r_alarm_led <= 1'b0;
                        r_snoozing  <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        // Count loaded with the full snooze length expires on its last tick.
                        if (r_snooze_cnt == SC_W'(1)) begin
                            r_state     <= S_RINGING;
                            r_ring_cnt  <= '0;
                            r_led_phase <= 1'b1;
                            r_ringing   <= 1'b1;
                            r_alarm_led <= 1'b1;
                            r_snoozing  <= 1'b0;
                        end else begin
                            r_snooze_cnt <= r_snooze_cnt - SC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ringing   <= 1'b0;
                    r_alarm_led <= 1'b0;
                    r_snoozing  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.ringing   = r_ringing;
    assign bus.alarm_led = r_alarm_led;
    assign bus.snoozing  = r_snoozing;
endmodule
